// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI-lite constants, arbiter state encoding and owner codes for the
// core-side memory arbiter.
package ysyx_22050019_axi_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 64;
  localparam int unsigned DEFAULT_DATA_W = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/ysyx_22050019_arb2.sv
// Two-request grant picker (icache vs dcache). Fixed dcache priority by default;
// round-robin with an internal `last` register when YSYX_22050019_ARB_RR_EN is defined.
module ysyx_22050019_arb2
  import ysyx_22050019_axi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_grant_en,
  output logic o_gnt_d,
  output logic o_gnt_vld
);

  assign o_gnt_vld = i_req_ic | i_req_dc;

`ifdef YSYX_22050019_ARB_RR_EN
  logic r_last;

  // Resets to dcache so the icache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWN_D;
    end else if (i_grant_en && o_gnt_vld) begin
      r_last <= o_gnt_d;
    end
  end

  always_comb begin
    o_gnt_d = i_req_dc;
    if (i_req_ic && i_req_dc) begin
      o_gnt_d = (r_last == OWN_I);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_grant_en, i_req_ic};

  assign o_gnt_d = i_req_dc;
`endif

endmodule

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Single-transaction AXI-lite arbiter sharing the memory port between icache and dcache.
// Define YSYX_22050019_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module ysyx_22050019_mem_arbiter
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  // icache read
  input  logic                i_ar_valid,
  output logic                i_ar_ready,
  input  logic [ADDR_W-1:0]   i_ar_addr,
  output logic                i_r_valid,
  input  logic                i_r_ready,
  output logic [DATA_W-1:0]   i_r_data,
  output logic [1:0]          i_r_resp,
  // dcache read
  input  logic                d_ar_valid,
  output logic                d_ar_ready,
  input  logic [ADDR_W-1:0]   d_ar_addr,
  output logic                d_r_valid,
  input  logic                d_r_ready,
  output logic [DATA_W-1:0]   d_r_data,
  output logic [1:0]          d_r_resp,
  // dcache write
  input  logic                d_aw_valid,
  output logic                d_aw_ready,
  input  logic [ADDR_W-1:0]   d_aw_addr,
  input  logic                d_w_valid,
  output logic                d_w_ready,
  input  logic [DATA_W-1:0]   d_w_data,
  input  logic [DATA_W/8-1:0] d_w_strb,
  output logic                d_b_valid,
  input  logic                d_b_ready,
  output logic [1:0]          d_b_resp,
  // memory side
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [1:0]          m_b_resp
);

  arb_state_e r_state, w_state_nxt;
  logic       r_own, w_own_nxt;
  logic       r_ar_done, w_ar_done_nxt;
  logic       r_aw_done, w_aw_done_nxt;
  logic       r_w_done, w_w_done_nxt;

  logic w_idle, w_rd, w_wr, w_own_d;
  logic w_gnt_d, w_gnt_vld;

  assign w_idle  = (r_state == IDLE);
  assign w_rd    = (r_state == RD);
  assign w_wr    = (r_state == WR);
  assign w_own_d = (r_own == OWN_D);

  ysyx_22050019_arb2 u_arb2 (
    .clk        (clk),
    .rst        (rst),
    .i_req_ic   (i_ar_valid),
    .i_req_dc   (d_ar_valid | d_aw_valid),
    .i_grant_en (w_idle),
    .o_gnt_d    (w_gnt_d),
    .o_gnt_vld  (w_gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_own     <= OWN_I;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_own     <= w_own_nxt;
      r_ar_done <= w_ar_done_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_own_nxt     = r_own;
    w_ar_done_nxt = r_ar_done;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    unique case (r_state)
      IDLE: begin
        w_ar_done_nxt = 1'b0;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
        if (w_gnt_vld) begin
          w_own_nxt   = w_gnt_d ? OWN_D : OWN_I;
          // Within the dcache a pending write beats a pending read.
          w_state_nxt = (w_gnt_d && d_aw_valid) ? WR : RD;
        end
      end
      RD: begin
        if (m_ar_valid && m_ar_ready) w_ar_done_nxt = 1'b1;
        if (m_r_valid && m_r_ready) begin
          w_state_nxt   = IDLE;
          w_ar_done_nxt = 1'b0;
        end
      end
      WR: begin
        if (m_aw_valid && m_aw_ready) w_aw_done_nxt = 1'b1;
        if (m_w_valid && m_w_ready)   w_w_done_nxt  = 1'b1;
        if (m_b_valid && m_b_ready) begin
          w_state_nxt   = IDLE;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read address / data channels
  assign m_ar_valid = w_rd & ~r_ar_done & (w_own_d ? d_ar_valid : i_ar_valid);
  assign i_ar_ready = w_rd & ~w_own_d & ~r_ar_done & m_ar_ready;
  assign d_ar_ready = w_rd &  w_own_d & ~r_ar_done & m_ar_ready;
  assign m_ar_addr  = w_own_d ? d_ar_addr : i_ar_addr;

  assign i_r_valid  = w_rd & ~w_own_d & m_r_valid;
  assign d_r_valid  = w_rd &  w_own_d & m_r_valid;
  assign m_r_ready  = w_rd & (w_own_d ? d_r_ready : i_r_ready);
  assign i_r_data   = m_r_data;
  assign i_r_resp   = m_r_resp;
  assign d_r_data   = m_r_data;
  assign d_r_resp   = m_r_resp;

  // Write channels: AW and W complete independently, B ends the transaction.
  assign m_aw_valid = w_wr & ~r_aw_done & d_aw_valid;
  assign d_aw_ready = w_wr & ~r_aw_done & m_aw_ready;
  assign m_aw_addr  = d_aw_addr;

  assign m_w_valid  = w_wr & ~r_w_done & d_w_valid;
  assign d_w_ready  = w_wr & ~r_w_done & m_w_ready;
  assign m_w_data   = d_w_data;
  assign m_w_strb   = d_w_strb;

  assign d_b_valid  = w_wr & m_b_valid;
  assign m_b_ready  = w_wr & d_b_ready;
  assign d_b_resp   = m_b_resp;

endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// Directed self-checking bench for the icache/dcache memory arbiter (fixed or RR build).
module tb_ysyx_22050019_mem_arbiter;
  import ysyx_22050019_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ar_valid, i_ar_ready, i_r_valid, i_r_ready;
  logic [63:0] i_ar_addr, i_r_data;
  logic [1:0]  i_r_resp;
  logic        d_ar_valid, d_ar_ready, d_r_valid, d_r_ready;
  logic [63:0] d_ar_addr, d_r_data;
  logic [1:0]  d_r_resp;
  logic        d_aw_valid, d_aw_ready, d_w_valid, d_w_ready, d_b_valid, d_b_ready;
  logic [63:0] d_aw_addr, d_w_data;
  logic [7:0]  d_w_strb;
  logic [1:0]  d_b_resp;
  logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [63:0] m_ar_addr, m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [63:0] m_aw_addr, m_w_data;
  logic [7:0]  m_w_strb;
  logic [1:0]  m_b_resp;

  int checks = 0;
  int errors = 0;

`ifdef YSYX_22050019_ARB_RR_EN
  localparam bit FirstD  = 1'b0;
  localparam bit RepeatD = 1'b0;
`else
  localparam bit FirstD  = 1'b1;
  localparam bit RepeatD = 1'b1;
`endif

  localparam logic [63:0] AddrI = 64'h0000_0000_8000_2000;
  localparam logic [63:0] AddrD = 64'h0000_0000_8000_3000;

  always #5 clk = ~clk;

  ysyx_22050019_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ar_valid(i_ar_valid), .i_ar_ready(i_ar_ready), .i_ar_addr(i_ar_addr),
    .i_r_valid(i_r_valid), .i_r_ready(i_r_ready), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
    .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_addr(d_ar_addr),
    .d_r_valid(d_r_valid), .d_r_ready(d_r_ready), .d_r_data(d_r_data), .d_r_resp(d_r_resp),
    .d_aw_valid(d_aw_valid), .d_aw_ready(d_aw_ready), .d_aw_addr(d_aw_addr),
    .d_w_valid(d_w_valid), .d_w_ready(d_w_ready), .d_w_data(d_w_data), .d_w_strb(d_w_strb),
    .d_b_valid(d_b_valid), .d_b_ready(d_b_ready), .d_b_resp(d_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
  );

  // All valid/ready outputs of the arbiter packed together.
  function automatic logic [11:0] vr_outs();
    return {i_ar_ready, i_r_valid, d_ar_ready, d_r_valid, d_aw_ready, d_w_ready, d_b_valid,
            m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ar_valid = 0; i_ar_addr = '0; i_r_ready = 0;
    d_ar_valid = 0; d_ar_addr = '0; d_r_ready = 0;
    d_aw_valid = 0; d_aw_addr = '0; d_w_valid = 0; d_w_data = '0; d_w_strb = '0;
    d_b_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = '0; m_r_resp = '0;
    m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = '0;
  endtask

  // Memory accepts the pending AR, then returns one R beat that the owner takes.
  task automatic complete_read(input bit own_d, input logic [63:0] data, input logic [1:0] resp);
    m_ar_ready = 1;
    step();
    m_ar_ready = 0;
    if (own_d) d_ar_valid = 0;
    else i_ar_valid = 0;
    m_r_valid = 1; m_r_data = data; m_r_resp = resp;
    i_r_ready = 1; d_r_ready = 1;
    step();
    m_r_valid = 0; i_r_ready = 0; d_r_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    checks++;
    if (vr_outs() !== 12'h000) begin
      errors++; $display("FAIL reset_outs: got %h want 000", vr_outs());
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, IDLE);
    end
    rst = 0;
    step();
    checks++;
    if (vr_outs() !== 12'h000) begin
      errors++; $display("FAIL idle_outs: got %h want 000", vr_outs());
    end
  endtask

  task automatic test_icache_read();
    i_ar_valid = 1; i_ar_addr = 64'h0000_0000_8000_0000;
    #1;
    checks++;
    if (m_ar_valid !== 1'b0) begin
      errors++; $display("FAIL ird_no_comb_valid: got %b want 0", m_ar_valid);
    end
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL ird_ar: got v=%b a=%h want v=1 a=80000000", m_ar_valid, m_ar_addr);
    end
    m_ar_ready = 1;
    #1;
    checks++;
    if (i_ar_ready !== 1'b1 || d_ar_ready !== 1'b0) begin
      errors++; $display("FAIL ird_ar_ready: got i=%b d=%b want i=1 d=0", i_ar_ready, d_ar_ready);
    end
    step();
    m_ar_ready = 0; i_ar_valid = 0;
    m_r_valid = 1; m_r_data = 64'hDEAD_BEEF_0000_0001; m_r_resp = RESP_OKAY; i_r_ready = 1;
    #1;
    checks++;
    if (m_ar_valid !== 1'b0) begin
      errors++; $display("FAIL ird_ar_done: got %b want 0", m_ar_valid);
    end
    checks++;
    if (i_r_valid !== 1'b1 || i_r_data !== 64'hDEAD_BEEF_0000_0001 || d_r_valid !== 1'b0
        || m_r_ready !== 1'b1) begin
      errors++;
      $display("FAIL ird_r: got iv=%b data=%h dv=%b mrdy=%b want 1 deadbeef00000001 0 1",
               i_r_valid, i_r_data, d_r_valid, m_r_ready);
    end
    step();
    m_r_valid = 0; i_r_ready = 0;
    #1;
    checks++;
    if (dut.r_state !== IDLE || vr_outs() !== 12'h000) begin
      errors++; $display("FAIL ird_back_idle: got st=%0d outs=%h want 0 000", dut.r_state, vr_outs());
    end
  endtask

  task automatic test_tie();
    rst = 1; step(); rst = 0;
    i_ar_valid = 1; i_ar_addr = AddrI;
    d_ar_valid = 1; d_ar_addr = AddrD;
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== (FirstD ? AddrD : AddrI)) begin
      errors++; $display("FAIL tie_first: got v=%b a=%h want a=%h", m_ar_valid, m_ar_addr,
                         FirstD ? AddrD : AddrI);
    end
    complete_read(FirstD, 64'h1, RESP_OKAY);
    checks++;
    if (vr_outs() !== 12'h000) begin
      errors++; $display("FAIL tie_bubble: got %h want 000", vr_outs());
    end
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== (FirstD ? AddrI : AddrD)) begin
      errors++; $display("FAIL tie_second: got v=%b a=%h want a=%h", m_ar_valid, m_ar_addr,
                         FirstD ? AddrI : AddrD);
    end
    complete_read(!FirstD, 64'h2, RESP_OKAY);
    i_ar_valid = 1; d_ar_valid = 1;
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== (RepeatD ? AddrD : AddrI)) begin
      errors++; $display("FAIL tie_repeat: got v=%b a=%h want a=%h", m_ar_valid, m_ar_addr,
                         RepeatD ? AddrD : AddrI);
    end
    complete_read(RepeatD, 64'h3, RESP_OKAY);
    step();
    complete_read(!RepeatD, 64'h4, RESP_OKAY);
  endtask

  task automatic test_write();
    d_aw_valid = 1; d_aw_addr = 64'h0000_0000_8000_1000;
    d_w_valid = 1; d_w_data = 64'h1122_3344_5566_7788; d_w_strb = 8'hFF;
    m_aw_ready = 0; m_w_ready = 1;
    #1;
    checks++;
    if (m_aw_valid !== 1'b0 || m_w_valid !== 1'b0) begin
      errors++; $display("FAIL wr_no_comb: got aw=%b w=%b want 0 0", m_aw_valid, m_w_valid);
    end
    step();
    checks++;
    if (m_aw_valid !== 1'b1 || m_w_valid !== 1'b1 || m_aw_addr !== 64'h0000_0000_8000_1000
        || m_w_data !== 64'h1122_3344_5566_7788 || m_w_strb !== 8'hFF) begin
      errors++; $display("FAIL wr_fwd: got aw=%b w=%b a=%h d=%h s=%h", m_aw_valid, m_w_valid,
                         m_aw_addr, m_w_data, m_w_strb);
    end
    checks++;
    if (d_w_ready !== 1'b1 || d_aw_ready !== 1'b0) begin
      errors++; $display("FAIL wr_readies: got w=%b aw=%b want 1 0", d_w_ready, d_aw_ready);
    end
    // W done; keep the master's valid high to show the arbiter itself blocks a resend.
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (m_w_valid !== 1'b0 || d_w_ready !== 1'b0 || m_aw_valid !== 1'b1) begin
        errors++; $display("FAIL wr_w_done_%0d: got w=%b wrdy=%b aw=%b want 0 0 1",
                           i, m_w_valid, d_w_ready, m_aw_valid);
      end
    end
    m_aw_ready = 1;
    #1;
    checks++;
    if (d_aw_ready !== 1'b1) begin
      errors++; $display("FAIL wr_aw_ready: got %b want 1", d_aw_ready);
    end
    step();
    m_aw_ready = 0; m_w_ready = 0; d_aw_valid = 0; d_w_valid = 0;
    m_b_valid = 1; m_b_resp = RESP_OKAY; d_b_ready = 1;
    #1;
    checks++;
    if (m_aw_valid !== 1'b0 || d_b_valid !== 1'b1 || d_b_resp !== RESP_OKAY
        || m_b_ready !== 1'b1) begin
      errors++; $display("FAIL wr_b: got aw=%b bv=%b resp=%b brdy=%b want 0 1 00 1",
                         m_aw_valid, d_b_valid, d_b_resp, m_b_ready);
    end
    step();
    m_b_valid = 0; d_b_ready = 0;
    #1;
    checks++;
    if (dut.r_state !== IDLE || vr_outs() !== 12'h000) begin
      errors++; $display("FAIL wr_back_idle: got st=%0d outs=%h", dut.r_state, vr_outs());
    end
  endtask

  task automatic test_write_beats_read();
    d_ar_valid = 1; d_ar_addr = AddrD;
    d_aw_valid = 1; d_aw_addr = 64'h0000_0000_8000_4000;
    d_w_valid = 1; d_w_data = 64'h55; d_w_strb = 8'h0F;
    step();
    checks++;
    if (m_aw_valid !== 1'b1 || m_ar_valid !== 1'b0) begin
      errors++; $display("FAIL wbr_grant: got aw=%b ar=%b want 1 0", m_aw_valid, m_ar_valid);
    end
    m_aw_ready = 1; m_w_ready = 1;
    step();
    m_aw_ready = 0; m_w_ready = 0; d_aw_valid = 0; d_w_valid = 0;
    m_b_valid = 1; d_b_ready = 1;
    step();
    m_b_valid = 0; d_b_ready = 0;
    #1;
    checks++;
    if (m_ar_valid !== 1'b0) begin
      errors++; $display("FAIL wbr_bubble: got ar=%b want 0", m_ar_valid);
    end
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== AddrD) begin
      errors++; $display("FAIL wbr_read: got v=%b a=%h want 1 %h", m_ar_valid, m_ar_addr, AddrD);
    end
    complete_read(1'b1, 64'h6, RESP_OKAY);
  endtask

  task automatic test_err_resp();
    d_ar_valid = 1; d_ar_addr = AddrD;
    step();
    m_ar_ready = 1;
    step();
    m_ar_ready = 0; d_ar_valid = 0;
    m_r_valid = 1; m_r_data = 64'hBAD; m_r_resp = RESP_SLVERR; d_r_ready = 1;
    #1;
    checks++;
    if (d_r_valid !== 1'b1 || d_r_resp !== RESP_SLVERR || i_r_valid !== 1'b0) begin
      errors++; $display("FAIL err_resp: got dv=%b resp=%b iv=%b want 1 10 0",
                         d_r_valid, d_r_resp, i_r_valid);
    end
    step();
    m_r_valid = 0; d_r_ready = 0; m_r_resp = RESP_OKAY;
    i_ar_valid = 1; i_ar_addr = AddrI;
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== AddrI) begin
      errors++; $display("FAIL err_recover: got v=%b a=%h want 1 %h", m_ar_valid, m_ar_addr, AddrI);
    end
    complete_read(1'b0, 64'h7, RESP_OKAY);
  endtask

  task automatic test_reset_mid();
    i_ar_valid = 1; i_ar_addr = AddrI;
    step();
    m_ar_ready = 1;
    step();
    m_ar_ready = 0; i_ar_valid = 0; i_r_ready = 1;
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (vr_outs() !== 12'h000 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL rst_mid: got outs=%h st=%0d want 000 0", vr_outs(), dut.r_state);
    end
    i_r_ready = 0;
    i_ar_valid = 1; i_ar_addr = 64'h0000_0000_8000_5000;
    step();
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== 64'h0000_0000_8000_5000 || r_own_is_i() !== 1'b1) begin
      errors++; $display("FAIL rst_mid_new: got v=%b a=%h", m_ar_valid, m_ar_addr);
    end
    complete_read(1'b0, 64'h8, RESP_OKAY);
  endtask

  function automatic logic r_own_is_i();
    return (i_ar_ready | m_ar_ready | 1'b1) & (dut.r_own == OWN_I);
  endfunction

  initial begin
    test_reset();
    test_icache_read();
    test_tie();
    test_write();
    test_write_beats_read();
    test_err_resp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_mem_arbiter.md
Name: ysyx_22050019_mem_arbiter

Overview:
- Shares the single core-side memory AXI-lite port between the icache (read-only) and the dcache (read, plus single-beat writeback and uncached writes).
- Sits between the two caches' `cache_*` master ports and the memory/crossbar slave.
- Serves one transaction at a time, with no outstanding or interleaved transfers.
- Grant is held from the winning valid until that transaction's final handshake (R or B).

Parameters:
- ADDR_W, 64, address width of all AR/AW channels
- DATA_W, 64, data width of R/W channels; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- i_ar_valid/i_ar_ready/i_ar_addr  in/out/in  1/1/ADDR_W  icache read address
- i_r_valid/i_r_ready/i_r_data/i_r_resp  out/in/out/out  1/1/DATA_W/2  icache read data
- d_ar_valid/d_ar_ready/d_ar_addr  in/out/in  1/1/ADDR_W  dcache read address
- d_r_valid/d_r_ready/d_r_data/d_r_resp  out/in/out/out  1/1/DATA_W/2  dcache read data
- d_aw_valid/d_aw_ready/d_aw_addr  in/out/in  1/1/ADDR_W  dcache write address
- d_w_valid/d_w_ready/d_w_data/d_w_strb  in/out/in/in  1/1/DATA_W/DATA_W/8  dcache write data
- d_b_valid/d_b_ready/d_b_resp  out/in/out  1/1/2  dcache write response
- m_ar_valid/m_ar_ready/m_ar_addr  out/in/out  1/1/ADDR_W  memory read address
- m_r_valid/m_r_ready/m_r_data/m_r_resp  in/out/in/in  1/1/DATA_W/2  memory read data
- m_aw_valid/m_aw_ready/m_aw_addr  out/in/out  1/1/ADDR_W  memory write address
- m_w_valid/m_w_ready/m_w_data/m_w_strb  out/in/out/out  1/1/DATA_W/DATA_W/8  memory write data
- m_b_valid/m_b_ready/m_b_resp  in/out/in  1/1/2  memory write response

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- State register encoding: IDLE, RD, WR.
- Owner register: `own` (0 = icache, 1 = dcache).
- Per-transaction done flags: `ar_done`, `aw_done`, `w_done`.

State transitions:
- IDLE: a grant is chosen from the valids sampled this cycle and registered.
  - d_aw_valid wins over d_ar_valid, giving WR with own=1.
  - Otherwise a read winner gives RD.
  - No valid keeps IDLE.
- RD: `m_ar_valid = owner ar_valid & ~ar_done`. The owner's ar_ready mirrors m_ar_ready; `ar_done` is set on the m_ar handshake.
  - R channel: m_r_* routes to the owner and the owner's r_ready routes to m_r_ready.
  - Exit: the m_r handshake returns to IDLE and clears the flags.
- WR: AW and W are forwarded concurrently, gated by `aw_done` / `w_done` independently.
  - B channel routes to the dcache.
  - Exit: the m_b handshake returns to IDLE.

Outputs and forwarding:
- Non-owner ready/valid outputs, and all m_* valids/readies in IDLE, are 0.
- Data, address, resp and strb outputs are pure pass-through muxes on `own`. They are don't-care when the matching valid is low.
- All valid/ready outputs are decoded from registered state only. They are never combinational from a same-cycle request in IDLE.

Latency:
- A request seen at cycle N in IDLE drives m_*_valid at N+1.
- Back-to-back transactions incur exactly one IDLE bubble cycle.

Priority (macro absent):
- Fixed order: dcache write > dcache read > icache read.
- icache can starve while the dcache streams requests; this is accepted.

Boundary conditions:
- Simultaneous i_ar and d_ar in IDLE: the winner is per the arbitration rule. The loser's valid stays high and is served in the next IDLE.
- A master dropping valid before its handshake is illegal and unsupported. The grant is still held until R/B completes.
- Non-OKAY resp values are forwarded unchanged to the owner; the arbiter takes no other action.
- rst at any state, including mid-burst: next state is IDLE, flags and `own` clear, and all valids/readies are 0 on the following cycle. Caches and memory are reset by the same `rst`.

Optional Feature:
- Macro: YSYX_22050019_ARB_RR_EN.
- Defined: round-robin between icache and dcache.
  - A 1-bit `last` register is updated at each grant.
  - On simultaneous requests, the side opposite `last` wins.
  - Within the dcache, write still beats read.
  - `last` resets to 1, so icache wins the first tie.
- Undefined: the fixed priority above; no `last` register exists.

Decomposition:
- Package ysyx_22050019_axi_pkg holds:
  - ADDR_W and DATA_W defaults
  - resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - the state enum {IDLE, RD, WR}
  - owner constants OWN_I=0 and OWN_D=1
- Sub-module ysyx_22050019_arb2: 2-request grant picker, fixed or round-robin per the macro. It is combinational with the `last` register inside.

Test Plan:
- i_ar_valid=1, addr 0x8000_0000, in IDLE at cycle 0:
  - m_ar_valid=1 with addr 0x8000_0000 at cycle 1.
  - m_r data 0xDEAD_BEEF_0000_0001 returns on i_r_data, d_r_valid stays 0, state is IDLE after the r handshake.
- i_ar and d_ar both valid at cycle 0:
  - Fixed mode: dcache is served first and icache follows after one bubble.
  - RR build: icache first, then dcache, then icache on a repeated tie.
- dcache AW addr 0x8000_1000 and W data 0x1122_3344_5566_7788, strb 0xFF, with m_aw_ready delayed 3 cycles and m_w_ready immediate:
  - w_done is set first and W is not re-sent.
  - B resp 2'b00 reaches the dcache and the arbiter then returns to IDLE.
- d_aw and d_ar both valid: WR is granted first; the read address appears on m_ar only after the B handshake plus one cycle.
- m_r_resp=2'b10 on a dcache read: d_r_resp=2'b10 is forwarded and the arbiter recovers normally.
- rst asserted in RD after the AR handshake but before R: at the next cycle all valid/ready outputs are 0 and state is IDLE, and a new i_ar is served normally.
